// File: rtl/csa_resolver_if.sv
// Handshake bundle for csa_resolver.
//   Input side : i_valid / o_ready, carrying i_sum and i_carry (D bits each).
//   Output side: o_valid / i_ready, carrying o_result (D+2) and o_iters.
// Signal names are seen from the resolver's side; slave = resolver,
// master = producer/consumer driving it.
interface csa_resolver_if #(
  parameter int D = 16
);
  localparam int W  = D + 2;
  localparam int CW = $clog2(D + 3);

  logic          i_valid;
  logic          o_ready;
  logic [D-1:0]  i_sum;
  logic [D-1:0]  i_carry;
  logic          o_valid;
  logic          i_ready;
  logic [W-1:0]  o_result;
  logic [CW-1:0] o_iters;

  modport slave (
    input  i_valid, i_sum, i_carry, i_ready,
    output o_ready, o_valid, o_result, o_iters
  );

  modport master (
    output i_valid, i_sum, i_carry, i_ready,
    input  o_ready, o_valid, o_result, o_iters
  );
endinterface

// File: rtl/csa_resolver.sv
// csa_resolver: resolves one carry-save pair to a binary sum,
//   o_result = i_sum + (i_carry << 1)
// by iterating one XOR/AND ripple step per cycle until the carry word is zero.
// Ports:
//   i_clk   - clock, rising edge
//   i_rst_n - asynchronous reset, active low
//   bus     - csa_resolver_if.slave: input pair (i_valid/o_ready/i_sum/i_carry)
//             and result (o_valid/i_ready/o_result/o_iters)
// One pair in flight; o_ready only in IDLE, o_valid only in DONE, both registered.
module csa_resolver #(
  parameter int D = 16
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  csa_resolver_if.slave  bus
);
  localparam int W  = D + 2;
  localparam int CW = $clog2(D + 3);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        r_state;
  logic [W-1:0]  r_s;
  logic [W-1:0]  r_c;
  logic [CW-1:0] r_cnt;
  logic          r_ready;
  logic          r_valid;

  // Next ripple step. The AND term's top bit shifted out is always zero since
  // s + c never exceeds 3*2^D - 3, which fits in W bits.
  logic [W-1:0]  w_s_nxt;
  logic [W-1:0]  w_c_nxt;
  assign w_s_nxt = r_s ^ r_c;
  assign w_c_nxt = (r_s & r_c) << 1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_c     <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.i_valid) begin
            r_s     <= {2'b00, bus.i_sum};
            r_c     <= {1'b0, bus.i_carry, 1'b0};
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (r_c == '0) begin
            r_valid <= 1'b1;
            r_state <= DONE;
          end else begin
            r_s   <= w_s_nxt;
            r_c   <= w_c_nxt;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          // Result held indefinitely under backpressure; values persist after transfer.
          if (bus.i_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_ready  = r_ready;
  assign bus.o_valid  = r_valid;
  assign bus.o_result = r_s;
  assign bus.o_iters  = r_cnt;
endmodule

// File: tb/tb_csa_resolver.sv
// Self-checking bench for csa_resolver (D=16): directed corner cases, reset
// mid-run, backpressure, then randomized pairs against an arithmetic model.
module tb_csa_resolver;
  localparam int D = 16;
  localparam int W = D + 2;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  int   n_chk = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  always #5 i_clk = ~i_clk;

  csa_resolver_if #(.D(D)) bus ();

  csa_resolver #(.D(D)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected sum by plain addition; iteration count from repeatedly applying
  // the half-adder identity a + b = (a ^ b) + 2*(a & b) until nothing is left over.
  function automatic void model(input logic [D-1:0] s, input logic [D-1:0] c,
                                output logic [W-1:0] res, output int k);
    int unsigned a, b, t;
    res = W'(s) + W'(c) * 2;
    a = s;
    b = c * 2;
    k = 0;
    while (b != 0 && k < 64) begin
      t = a & b;
      a = a ^ b;
      b = (t * 2) % (1 << W);
      k++;
    end
  endfunction

  // Handshake exclusivity watched every cycle once out of reset.
  always @(negedge i_clk) begin
    if (mon_en) chk("rdy_vld_excl", 32'(bus.o_ready & bus.o_valid), 32'd0);
  end

  task automatic run_pair(input logic [D-1:0] s, input logic [D-1:0] c, input int hold);
    logic [W-1:0] er;
    int ek, lat, w;
    model(s, c, er, ek);
    w = 0;
    while (!bus.o_ready && w < 10) begin @(negedge i_clk); w++; end
    chk("rdy_idle", 32'(bus.o_ready), 32'd1);
    bus.i_valid = 1'b1;
    bus.i_sum   = s;
    bus.i_carry = c;
    @(posedge i_clk);
    lat = 1;
    @(negedge i_clk);
    // Scramble inputs after accept; the stored pair must be unaffected.
    bus.i_valid = 1'b0;
    bus.i_sum   = D'($urandom);
    bus.i_carry = D'($urandom);
    chk("rdy_busy", 32'(bus.o_ready), 32'd0);
    while (!bus.o_valid && lat < 40) begin
      @(posedge i_clk); lat++; @(negedge i_clk);
    end
    chk("latency", 32'(lat), 32'(ek + 2));
    chk("result", 32'(bus.o_result), 32'(er));
    chk("iters", 32'(bus.o_iters), 32'(ek));
    chk("iters_max", 32'(bus.o_iters <= W), 32'd1);
    repeat (hold) begin
      @(negedge i_clk);
      chk("bp_vld", 32'(bus.o_valid), 32'd1);
      chk("bp_res", 32'(bus.o_result), 32'(er));
      chk("bp_rdy", 32'(bus.o_ready), 32'd0);
    end
    bus.i_ready = 1'b1;
    @(negedge i_clk);
    bus.i_ready = 1'b0;
    chk("vld_drop", 32'(bus.o_valid), 32'd0);
    chk("rdy_back", 32'(bus.o_ready), 32'd1);
    chk("res_keep", 32'(bus.o_result), 32'(er));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_valid = 1'b1;  // ignored while in reset
    bus.i_sum   = 16'hABCD;
    bus.i_carry = 16'h1234;
    bus.i_ready = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_ready", 32'(bus.o_ready), 32'd1);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_result", 32'(bus.o_result), 32'd0);
    chk("rst_iters", 32'(bus.o_iters), 32'd0);
    bus.i_valid = 1'b0;
    i_rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge i_clk);

    // Directed corners with absolute expectations.
    run_pair(16'h0000, 16'h0000, 0);
    chk("zero_res", 32'(bus.o_result), 32'h0);
    run_pair(16'hFFFF, 16'h0001, 0);
    chk("ripple_res", 32'(bus.o_result), 32'h10001);
    chk("ripple_iters", 32'(bus.o_iters), 32'd16);
    run_pair(16'hFFFF, 16'hFFFF, 10);
    chk("full_res", 32'(bus.o_result), 32'h2FFFD);
    chk("full_iters", 32'(bus.o_iters), 32'd3);

    // Reset during the long ripple, after 5 iterations.
    bus.i_valid = 1'b1;
    bus.i_sum   = 16'hFFFF;
    bus.i_carry = 16'h0001;
    @(posedge i_clk);
    @(negedge i_clk);
    bus.i_valid = 1'b0;
    repeat (5) @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(bus.o_ready), 32'd1);
    chk("mid_rst_valid", 32'(bus.o_valid), 32'd0);
    chk("mid_rst_result", 32'(bus.o_result), 32'd0);
    chk("mid_rst_iters", 32'(bus.o_iters), 32'd0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (25) begin
      @(negedge i_clk);
      chk("post_rst_vld", 32'(bus.o_valid), 32'd0);
      chk("post_rst_rdy", 32'(bus.o_ready), 32'd1);
    end

    // Randomized pairs, random idle gaps and backpressure.
    for (int n = 0; n < 2000; n++) begin
      logic [D-1:0] rs, rc;
      rs = D'($urandom);
      rc = D'($urandom);
      case ($urandom_range(0, 7))
        0: rc = '0;
        1: rs = '1;
        2: rc = '1;
        3: begin rs = '1; rc = D'(1) << $urandom_range(0, D-1); end
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) @(negedge i_clk);
      run_pair(rs, rc, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
